// File: rtl/step_line_parser.sv
// rtl/step_line_parser.sv - ASCII command line parser (L/R + decimal count) for the dial solution core
//
// Ports:
//   clk, rst                 sole clock, synchronous active-high reset
//   in_valid/in_data/in_last byte source; a byte moves when in_valid && in_ready
//   in_ready                 high while neither error nor done is set
//   valid                    one-cycle pulse per parsed line
//   step_direction           0 = L, 1 = R (held between pulses)
//   step_count               decimal magnitude of the line (held between pulses)
//   error                    sticky, malformed input seen
//   done                     sticky, final byte consumed cleanly
module step_line_parser #(
    parameter int COUNT_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               valid,
    output logic               step_direction,
    output logic [COUNT_W-1:0] step_count,
    output logic               error,
    output logic               done
);

    // Four spare bits hold acc*10+9 for any in-range acc, so overflow is a plain compare.
    localparam int ACC_W = COUNT_W + 4;
    localparam logic [ACC_W-1:0] MAX_COUNT = {4'b0000, {COUNT_W{1'b1}}};

    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIR,
        S_NUM,
        S_ERR,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               dir_q, dir_d;
    logic [COUNT_W-1:0] acc_q, acc_d;
    logic               valid_q, valid_d;
    logic               step_direction_q, step_direction_d;
    logic [COUNT_W-1:0] step_count_q, step_count_d;
    logic               error_q, error_d;
    logic               done_q, done_d;

    logic               take;
    logic               emit;
    logic               is_digit;
    logic [3:0]         digit;
    logic [ACC_W-1:0]   next_acc;

    assign in_ready       = !error_q && !done_q;
    assign valid          = valid_q;
    assign step_direction = step_direction_q;
    assign step_count     = step_count_q;
    assign error          = error_q;
    assign done           = done_q;

    always_comb begin
        state_d          = state_q;
        dir_d            = dir_q;
        acc_d            = acc_q;
        valid_d          = 1'b0;
        step_direction_d = step_direction_q;
        step_count_d     = step_count_q;
        emit             = 1'b0;

        take     = in_valid && in_ready;
        is_digit = (in_data >= CH_0) && (in_data <= CH_9);
        // ASCII '0'..'9' carry their value in the low nibble.
        digit    = in_data[3:0];
        next_acc = ACC_W'(acc_q) * ACC_W'(10) + ACC_W'(digit);

        if (take) begin
            case (state_q)
                S_IDLE: begin
                    if (in_data == CH_L || in_data == CH_R) begin
                        dir_d   = (in_data == CH_R);
                        acc_d   = '0;
                        state_d = S_DIR;
                    end else if (in_data != CH_LF && in_data != CH_CR && in_data != CH_SP) begin
                        state_d = S_ERR;
                    end
                end
                S_DIR: begin
                    if (is_digit) begin
                        acc_d   = COUNT_W'(digit);
                        state_d = S_NUM;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_NUM: begin
                    if (is_digit) begin
                        if (next_acc > MAX_COUNT) begin
                            state_d = S_ERR;
                        end else begin
                            acc_d = next_acc[COUNT_W-1:0];
                        end
                    end else if (in_data == CH_LF) begin
                        emit    = 1'b1;
                        state_d = S_IDLE;
                    end else if (in_data != CH_CR) begin
                        state_d = S_ERR;
                    end
                end
                default: ;
            endcase

            // The final byte closes any open number as if a newline followed it;
            // an error raised by the byte itself takes precedence.
            if (in_last) begin
                case (state_d)
                    S_NUM: begin
                        emit    = 1'b1;
                        state_d = S_DONE;
                    end
                    S_IDLE:  state_d = S_DONE;
                    S_DIR:   state_d = S_ERR;
                    default: ;
                endcase
            end
        end

        if (emit) begin
            valid_d          = 1'b1;
            step_direction_d = dir_d;
            step_count_d     = acc_d;
        end

        error_d = (state_d == S_ERR);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            dir_q            <= 1'b0;
            acc_q            <= '0;
            valid_q          <= 1'b0;
            step_direction_q <= 1'b0;
            step_count_q     <= '0;
            error_q          <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            dir_q            <= dir_d;
            acc_q            <= acc_d;
            valid_q          <= valid_d;
            step_direction_q <= step_direction_d;
            step_count_q     <= step_count_d;
            error_q          <= error_d;
            done_q           <= done_d;
        end
    end

endmodule

// File: tb/tb_step_line_parser.sv
// tb/tb_step_line_parser.sv - scoreboard bench for step_line_parser with a line-level reference model
module tb_step_line_parser;

    localparam int COUNT_W = 10;
    localparam int MAXV    = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_last;
    logic               in_ready;
    logic               valid;
    logic               step_direction;
    logic [COUNT_W-1:0] step_count;
    logic               error;
    logic               done;

    step_line_parser #(.COUNT_W(COUNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .valid          (valid),
        .step_direction (step_direction),
        .step_count     (step_count),
        .error          (error),
        .done           (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        bit dir;
        int cnt;
        int at;
    } cmd_t;

    cmd_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the line seen so far, tracked as text-level facts
    // (direction letter present, digit count, numeric value as an unbounded int).
    bit m_have_dir;
    int m_ndig;
    int m_val;
    bit m_dir;
    bit m_err;
    bit m_done;

    function automatic bit is_dig(input byte b);
        return b >= "0" && b <= "9";
    endfunction

    task automatic model_reset();
        m_have_dir = 0; m_ndig = 0; m_val = 0; m_dir = 0; m_err = 0; m_done = 0;
    endtask

    task automatic model_emit(input int at);
        cmd_t c;
        c.dir = m_dir; c.cnt = m_val; c.at = at;
        exp_q.push_back(c);
    endtask

    task automatic model_byte(input byte b, input bit last, input int at);
        if (!m_have_dir) begin
            if (b == "L" || b == "R") begin
                m_have_dir = 1; m_dir = (b == "R"); m_ndig = 0; m_val = 0;
            end else if (!(b == 8'h0A || b == 8'h0D || b == " ")) begin
                m_err = 1;
            end
        end else if (is_dig(b)) begin
            m_val  = m_val * 10 + (b - "0");
            m_ndig = m_ndig + 1;
            if (m_val > MAXV) m_err = 1;
        end else if (b == 8'h0A) begin
            if (m_ndig == 0) m_err = 1;
            else begin
                model_emit(at);
                m_have_dir = 0;
            end
        end else if (!(b == 8'h0D && m_ndig > 0)) begin
            m_err = 1;
        end
        if (last && !m_err) begin
            if (m_have_dir && m_ndig == 0) m_err = 1;
            else begin
                if (m_have_dir) model_emit(at);
                m_done = 1;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected command, including its cycle.
    always @(negedge clk) begin
        if (valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got dir=%0d cnt=%0d at %0d, none expected",
                         step_direction, step_count, cyc);
            end else begin
                cmd_t e;
                e = exp_q.pop_front();
                if (step_direction != e.dir || int'(step_count) != e.cnt || cyc != e.at) begin
                    bad++;
                    $display("FAIL pulse: got dir=%0d cnt=%0d at %0d expected dir=%0d cnt=%0d at %0d",
                             step_direction, step_count, cyc, e.dir, e.cnt, e.at);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 0;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input byte b, input bit last, input int gapmax);
        bit rdy;
        if (gapmax > 0) idle($urandom_range(0, gapmax));
        in_valid = 1; in_data = b; in_last = last;
        #1;
        rdy = in_ready;
        check("in_ready", int'(in_ready), int'(!(m_err || m_done)));
        @(posedge clk); #1;
        if (rdy) model_byte(b, last, cyc);
        in_valid = 0; in_last = 0;
    endtask

    task automatic send_str(input string s, input bit last_on_end, input int gapmax);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last_on_end && (i == s.len() - 1), gapmax);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_dir"}, int'(step_direction), 0);
        check({tag, "_count"}, int'(step_count), 0);
        check({tag, "_error"}, int'(error), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_in_ready"}, int'(in_ready), 1);
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; in_last = 0; in_data = 0;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        check_reset_outputs("reset");
    endtask

    task automatic check_flags(input string tag);
        idle(2);
        check({tag, "_error"}, int'(error), int'(m_err));
        check({tag, "_done"}, int'(done), int'(m_done));
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        string s;
        rst = 1; in_valid = 0; in_last = 0; in_data = 0;
        model_reset();
        idle(2);
        do_reset();

        // Two commands back to back; second pulse lands 4 cycles after the first.
        send_str("L68\nR30\n", 0, 0);
        check_flags("basic");

        // Blank lines and CR are silent; max count and zero are both legal.
        send_str("\r\nR1023\r\n\nL0\n", 0, 0);
        check_flags("bounds");

        // Overflow one past max, then the newline must not be consumed.
        send_str("R1024\n", 0, 0);
        check("overflow_error", int'(error), 1);
        check("overflow_in_ready", int'(in_ready), 0);
        check_flags("overflow");
        do_reset();
        send_str("L5\n", 0, 0);
        check_flags("after_rst");

        do_reset();
        send_str("L\n", 0, 0);
        check_flags("no_digits");
        do_reset();
        send_str("X", 0, 0);
        check_flags("bad_char");

        // Final byte closes the number; further bytes are refused.
        do_reset();
        send_str("R12", 1, 3);
        check("last_done", int'(done), 1);
        check("last_in_ready", int'(in_ready), 0);
        send_str("L4\n", 0, 2);
        check_flags("last");

        // Reset arriving with a byte on the bus discards the partial line.
        do_reset();
        send_str("L9", 0, 0);
        in_valid = 1; in_data = "9"; rst = 1;
        @(posedge clk); #1;
        rst = 0; in_valid = 0;
        model_reset();
        check_reset_outputs("midline");
        send_str("R3\n", 0, 0);
        check_flags("post_midline");

        // Randomised lines with leading zeros, CRs, blanks, occasional garbage and gaps.
        for (int r = 0; r < 12; r++) begin
            int nl;
            do_reset();
            nl = $urandom_range(2, 7);
            for (int l = 0; l < nl; l++) begin
                bit lastline;
                lastline = (l == nl - 1);
                s = "";
                if ($urandom_range(0, 4) == 0) s = {s, "\n"};
                if ($urandom_range(0, 5) == 0) s = {s, " "};
                s = {s, ($urandom_range(0, 1) != 0) ? "R" : "L"};
                for (int z = $urandom_range(0, 3); z > 0; z--) if ($urandom_range(0, 2) == 0) s = {s, "0"};
                if ($urandom_range(0, 9) != 0) s = {s, $sformatf("%0d", $urandom_range(0, 1100))};
                if ($urandom_range(0, 3) == 0) s = {s, "\r"};
                if ($urandom_range(0, 11) == 0) s = {s, "x"};
                if (!lastline || $urandom_range(0, 1) != 0) s = {s, "\n"};
                send_str(s, lastline, $urandom_range(0, 1) * 2);
            end
            check_flags("random");
        end

        idle(3);
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation ran past its bound");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
